packet_router_buffer: RTL and testbench
=======================================

// Module: packet_router_buffer
// PURPOSE
//  Store-and-forward packet stage between the NoC link and the router outputs. Flits are
//  buffered in a DEPTH-entry FIFO; once a whole packet is held, it is streamed to the local
//  CPU port, the forward port or both (broadcast), chosen by the head-flit destination.
//  Malformed and oversize packets are repaired or dropped and counted.
// PARAMETERS
//  FLIT_W    64  flit width; [FLIT_W-1:FLIT_W-2]=type: 00 HEAD, 01 BODY, 10 TAIL, 11 SINGLE
//  ID_W       8  destination field width = HEAD/SINGLE flit bits [ID_W-1:0]
//  DEPTH     16  FIFO entries, power of 2, >=4
//  BCAST_ID  '1  destination value meaning "deliver to both ports"
// PORTS
//  nocclk                        in   1        clock
//  rst_n                         in   1        async active-low reset
//  node_id                       in   ID_W     this node's id; quasi-static
//  next_flit                     in   FLIT_W   incoming flit
//  next_flit_valid               in   1        incoming flit valid
//  next_flit_ready               out  1        block accepts next_flit
//  noc_to_cpu_pushed_flit        out  FLIT_W   flit to local CPU
//  noc_to_cpu_pushed_flit_valid  out  1
//  noc_to_cpu_pushed_flit_ready  in   1
//  forwarded_flit                out  FLIT_W   flit to router
//  forwarded_flit_valid          out  1
//  forwarded_flit_ready          in   1
//  pkt_count                     out  $clog2(DEPTH+1)  complete packets held
//  err_count                     out  16       protocol-error count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, pkt_count=0, err_count=0, all valids 0, in-FSM
//  EXPECT_HEAD, out-FSM IDLE. next_flit_ready=0 while rst_n=0.
//  Transfer = valid&&ready on the rising nocclk edge; valid never depends on ready.
//  FIFO entry = flit + eop bit. next_flit_ready = (in_state==DROP) || !full (registered count).
//  Input FSM:
//   EXPECT_HEAD: HEAD -> write, eop=0, IN_PKT. SINGLE -> write, eop=1, pkt_count++.
//     BODY/TAIL -> consume, do not write, err++.
//   IN_PKT: BODY -> write eop=0. TAIL -> write eop=1, pkt_count++, EXPECT_HEAD.
//     HEAD/SINGLE -> previous packet closed unterminated: pkt_count++, err++,
//     then the new flit is handled as in EXPECT_HEAD.
//   Oversize guard: in IN_PKT, a BODY that fills the last free entry while pkt_count==0 is
//     written with eop=1, pkt_count++, err++, -> DROP.
//   DROP: ready=1; consume without writing until TAIL (-> EXPECT_HEAD) or HEAD/SINGLE
//     (handled as in EXPECT_HEAD).
//  Output FSM:
//   IDLE: if pkt_count>0, latch dest from FIFO head. dest==BCAST_ID -> SEND_BOTH;
//     dest==node_id -> SEND_LOCAL; else SEND_FWD. Transition on the next edge.
//   SEND_*: FIFO head drives the selected port(s) with valid=1. SEND_BOTH keeps per-port
//     done flags: a port whose handshake completed drops its valid. The entry is popped
//     when every selected port has accepted it; then the done flags clear.
//   Ends after popping an eop entry: pkt_count--, -> IDLE. A HEAD/SINGLE at the FIFO head
//     while in SEND_* ends the packet without popping it (unterminated close).
//   A packet is never interleaved. The unused port's valid is 0.
//  Latency: a SINGLE accepted at edge N is presented on its port after edge N+2 (valid
//   during cycle N+2). Full-rate streaming after that: 1 flit/cycle.
//  Simultaneous events: push and pop in one cycle are both allowed, count unchanged.
//   pkt_count++ and -- in the same cycle cancel out. err increments once per cycle max
//   (the unterminated-close path counts 1).
//  FIFO pointers wrap modulo DEPTH. Full = DEPTH entries, empty = 0. No overwrite; no pop
//   when empty.
//  Reset mid-packet: everything is discarded and valids drop immediately (async).
// TESTING
//  1 node_id=5, SINGLE dest 5 -> cpu valid 2 cycles later, forward valid stays 0,
//    pkt_count 1->0.
//  2 HEAD(dest 9),BODY,BODY,TAIL, cpu/fwd ready=1 -> 4 flits on forwarded_flit in order,
//    no output before the TAIL is accepted.
//  3 Broadcast 3-flit packet: fwd ready=1, cpu ready held 0 for 3 cycles -> each flit
//    seen exactly once per port, pop only after both accept.
//  4 BODY with no HEAD, then HEAD,BODY,HEAD(SINGLE) -> err_count=2, first packet 2 flits
//    closed unterminated, SINGLE delivered next.
//  5 DEPTH=4, HEAD+5 BODY+TAIL, outputs stalled -> 4 flits stored, last eop=1, err=1,
//    remaining flits consumed in DROP, ready stays 1.
//  6 Assert rst_n low mid-stream with FIFO at 3 entries -> all valids 0, pkt_count 0;
//    a fresh SINGLE after release is delivered normally.

Source files
------------

// File: rtl/packet_router_buffer.sv
// Store-and-forward packet buffer between the NoC link and the router outputs.
// Incoming flits are queued with an end-of-packet marker. A packet is streamed
// out only after it has been fully stored. Its destination selects the local
// CPU port, the forward port, or both ports for a broadcast. Packets that are
// malformed or too large are repaired or dropped, and each case is counted.
//
// Handshake (all three ports): a flit transfers on the rising nocclk edge where
// valid && ready. A valid never depends on the ready it is paired with. Once a
// flit is offered, it stays stable until it is accepted.
module packet_router_buffer #(
  parameter int              FLIT_W   = 64,
  parameter int              ID_W     = 8,
  parameter int              DEPTH    = 16,
  parameter logic [ID_W-1:0] BCAST_ID = '1
) (
  input  logic                       nocclk,
  input  logic                       rst_n,
  input  logic [ID_W-1:0]            node_id,
  input  logic [FLIT_W-1:0]          next_flit,
  input  logic                       next_flit_valid,
  output logic                       next_flit_ready,
  output logic [FLIT_W-1:0]          noc_to_cpu_pushed_flit,
  output logic                       noc_to_cpu_pushed_flit_valid,
  input  logic                       noc_to_cpu_pushed_flit_ready,
  output logic [FLIT_W-1:0]          forwarded_flit,
  output logic                       forwarded_flit_valid,
  input  logic                       forwarded_flit_ready,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count,
  output logic [15:0]                err_count,
  output logic [1:0]                 dbg_in_state,
  output logic [2:0]                 dbg_out_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] T_HEAD   = 2'b00;
  localparam logic [1:0] T_BODY   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic [1:0] {EXPECT_HEAD, IN_PKT, DROP} in_state_t;
  typedef enum logic [2:0] {IDLE, ROUTE, SEND_LOCAL, SEND_FWD, SEND_BOTH} out_state_t;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  // Each FIFO entry stores {eop, flit}.
  logic [FLIT_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty;

  logic            in_fire, in_start;
  logic [1:0]      in_type;
  logic            wr_en, wr_eop, err_inc;
  logic [1:0]      pkt_inc;

  logic [FLIT_W-1:0] head_flit;
  logic              head_eop, head_start;
  logic [ID_W-1:0]   dest_q;
  logic              first_q, cpu_done, fwd_done;
  logic              sending, end_unterm, present;
  logic              cpu_fire, fwd_fire, pop, pkt_dec;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // DROP always accepts flits. Otherwise, space in the FIFO is required.
  assign next_flit_ready = rst_n && ((in_state == DROP) || !full);
  assign in_fire  = next_flit_valid && next_flit_ready;
  assign in_type  = next_flit[FLIT_W-1 -: 2];
  assign in_start = (in_type == T_HEAD) || (in_type == T_SINGLE);

  // Input parser: decides the write, eop, packet-count and error updates for the accepted flit.
  always_comb begin
    in_next = in_state;
    wr_en   = 1'b0;
    wr_eop  = 1'b0;
    pkt_inc = 2'd0;
    err_inc = 1'b0;
    if (in_fire) begin
      case (in_state)
        EXPECT_HEAD: begin
          if (in_type == T_HEAD) begin
            wr_en   = 1'b1;
            in_next = IN_PKT;
          end else if (in_type == T_SINGLE) begin
            wr_en   = 1'b1;
            wr_eop  = 1'b1;
            pkt_inc = 2'd1;
          end else begin
            err_inc = 1'b1;
          end
        end
        IN_PKT: begin
          if (in_start) begin
            // Close the open packet without a tail, then start the new one.
            err_inc = 1'b1;
            wr_en   = 1'b1;
            if (in_type == T_SINGLE) begin
              wr_eop  = 1'b1;
              pkt_inc = 2'd2;
              in_next = EXPECT_HEAD;
            end else begin
              pkt_inc = 2'd1;
            end
          end else if (in_type == T_TAIL) begin
            wr_en   = 1'b1;
            wr_eop  = 1'b1;
            pkt_inc = 2'd1;
            in_next = EXPECT_HEAD;
          end else begin
            wr_en = 1'b1;
            // If the packet would take the whole FIFO, it could never be sent.
            // Truncate it here and discard the rest.
            if ((count == CW'(DEPTH-1)) && (pkt_count == '0)) begin
              wr_eop  = 1'b1;
              pkt_inc = 2'd1;
              err_inc = 1'b1;
              in_next = DROP;
            end
          end
        end
        DROP: begin
          if (in_type == T_TAIL) begin
            in_next = EXPECT_HEAD;
          end else if (in_start) begin
            if (full) begin
              // There is no room for the new packet, so it is lost as well.
              err_inc = 1'b1;
            end else if (in_type == T_HEAD) begin
              wr_en   = 1'b1;
              in_next = IN_PKT;
            end else begin
              wr_en   = 1'b1;
              wr_eop  = 1'b1;
              pkt_inc = 2'd1;
              in_next = EXPECT_HEAD;
            end
          end
        end
        default: in_next = EXPECT_HEAD;
      endcase
    end
  end

  assign head_flit  = mem[rd_ptr][FLIT_W-1:0];
  assign head_eop   = mem[rd_ptr][FLIT_W];
  assign head_start = (head_flit[FLIT_W-1 -: 2] == T_HEAD) ||
                      (head_flit[FLIT_W-1 -: 2] == T_SINGLE);

  assign sending    = (out_state == SEND_LOCAL) || (out_state == SEND_FWD) ||
                      (out_state == SEND_BOTH);
  // A start flit found after the first flit means the packet was closed without a tail.
  assign end_unterm = sending && !empty && !first_q && head_start;
  assign present    = sending && !empty && !end_unterm;

  assign noc_to_cpu_pushed_flit       = head_flit;
  assign forwarded_flit               = head_flit;
  assign noc_to_cpu_pushed_flit_valid = present && ((out_state == SEND_LOCAL) ||
                                        ((out_state == SEND_BOTH) && !cpu_done));
  assign forwarded_flit_valid         = present && ((out_state == SEND_FWD) ||
                                        ((out_state == SEND_BOTH) && !fwd_done));
  assign cpu_fire = noc_to_cpu_pushed_flit_valid && noc_to_cpu_pushed_flit_ready;
  assign fwd_fire = forwarded_flit_valid && forwarded_flit_ready;

  // Output sequencer: picks the route, then pops each entry after every selected port has taken it.
  always_comb begin
    out_next = out_state;
    pop      = 1'b0;
    case (out_state)
      IDLE:       if (pkt_count != '0) out_next = ROUTE;
      ROUTE: begin
        if (dest_q == BCAST_ID)     out_next = SEND_BOTH;
        else if (dest_q == node_id) out_next = SEND_LOCAL;
        else                        out_next = SEND_FWD;
      end
      SEND_LOCAL: pop = cpu_fire;
      SEND_FWD:   pop = fwd_fire;
      SEND_BOTH:  pop = present && (cpu_done || cpu_fire) && (fwd_done || fwd_fire);
      default:    out_next = IDLE;
    endcase
    pkt_dec = (pop && head_eop) || end_unterm;
    if (sending && pkt_dec) out_next = IDLE;
  end

  // FSM state, FIFO pointers and counters.
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      in_state  <= EXPECT_HEAD;
      out_state <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
      err_count <= '0;
      dest_q    <= '0;
      first_q   <= 1'b0;
      cpu_done  <= 1'b0;
      fwd_done  <= 1'b0;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count     <= count + CW'(wr_en) - CW'(pop);
      pkt_count <= pkt_count + CW'(pkt_inc) - CW'(pkt_dec);
      if (err_inc && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      if ((out_state == IDLE) && (pkt_count != '0)) dest_q <= head_flit[ID_W-1:0];
      if (out_state == ROUTE) first_q <= 1'b1;
      else if (pop)           first_q <= 1'b0;
      if (pop || (out_state != SEND_BOTH)) begin
        cpu_done <= 1'b0;
        fwd_done <= 1'b0;
      end else begin
        if (cpu_fire) cpu_done <= 1'b1;
        if (fwd_fire) fwd_done <= 1'b1;
      end
    end
  end

  // FIFO storage. The data is not reset, because the pointers decide which entries are valid.
  always_ff @(posedge nocclk) begin
    if (wr_en) mem[wr_ptr] <= {wr_eop, next_flit};
  end

  assign dbg_in_state  = in_state;
  assign dbg_out_state = out_state;

endmodule

// File: tb/tb_packet_router_buffer.sv
// Directed bench for packet_router_buffer with a 4-entry FIFO.
module tb_packet_router_buffer;

  localparam int FLIT_W = 64;
  localparam int ID_W   = 8;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  logic              nocclk = 1'b0;
  logic              rst_n;
  logic [ID_W-1:0]   node_id;
  logic [FLIT_W-1:0] next_flit;
  logic              next_flit_valid;
  logic              next_flit_ready;
  logic [FLIT_W-1:0] cpu_flit;
  logic              cpu_valid;
  logic              cpu_ready;
  logic [FLIT_W-1:0] fwd_flit;
  logic              fwd_valid;
  logic              fwd_ready;
  logic [CW-1:0]     pkt_count;
  logic [15:0]       err_count;
  logic [1:0]        dbg_in_state;
  logic [2:0]        dbg_out_state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [FLIT_W-1:0] cpu_got[$];
  logic [FLIT_W-1:0] fwd_got[$];
  logic [FLIT_W-1:0] cpu_exp_q[$];
  logic [FLIT_W-1:0] fwd_exp_q[$];
  int cpu_rd = 0;
  int fwd_rd = 0;

  logic [FLIT_W-1:0] f_h, f_b1, f_b2, f_b3, f_t;

  packet_router_buffer #(.FLIT_W(FLIT_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .nocclk                       (nocclk),
    .rst_n                        (rst_n),
    .node_id                      (node_id),
    .next_flit                    (next_flit),
    .next_flit_valid              (next_flit_valid),
    .next_flit_ready              (next_flit_ready),
    .noc_to_cpu_pushed_flit       (cpu_flit),
    .noc_to_cpu_pushed_flit_valid (cpu_valid),
    .noc_to_cpu_pushed_flit_ready (cpu_ready),
    .forwarded_flit               (fwd_flit),
    .forwarded_flit_valid         (fwd_valid),
    .forwarded_flit_ready         (fwd_ready),
    .pkt_count                    (pkt_count),
    .err_count                    (err_count),
    .dbg_in_state                 (dbg_in_state),
    .dbg_out_state                (dbg_out_state)
  );

  // Clock
  always #5 nocclk = ~nocclk;

  // Output monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge nocclk) begin
    if (rst_n && cpu_valid && cpu_ready) cpu_got.push_back(cpu_flit);
    if (rst_n && fwd_valid && fwd_ready) fwd_got.push_back(fwd_flit);
  end

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [7:0] tag,
                                           input logic [7:0] dest);
    return {t, 46'h0, tag, dest};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge nocclk);
      #1;
    end
  endtask

  // Offers one flit, waits for acceptance with a time limit, and returns 1 time unit after the accepting edge.
  task automatic push(input logic [FLIT_W-1:0] f);
    int waited;
    waited = 0;
    next_flit       = f;
    next_flit_valid = 1'b1;
    while (!next_flit_ready && waited < 50) begin
      tick(1);
      waited++;
    end
    if (!next_flit_ready) begin
      n_assert++;
      n_fail++;
      $error("FAIL push_timeout observed=ready0 expected=ready1");
    end
    tick(1);
    next_flit_valid = 1'b0;
  endtask

  // Compares the flits collected on one port since the last call with the expected queue.
  task automatic check_port(input string tag, input bit is_cpu);
    logic [FLIT_W-1:0] got[$];
    logic [FLIT_W-1:0] exp[$];
    if (is_cpu) begin
      for (int i = cpu_rd; i < cpu_got.size(); i++) got.push_back(cpu_got[i]);
      exp = cpu_exp_q;
      cpu_rd = cpu_got.size();
      cpu_exp_q.delete();
    end else begin
      for (int i = fwd_rd; i < fwd_got.size(); i++) got.push_back(fwd_got[i]);
      exp = fwd_exp_q;
      fwd_rd = fwd_got.size();
      fwd_exp_q.delete();
    end
    check({tag, "_n"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s_flit%0d", tag, i), (i < got.size()) ? got[i] : 'x, exp[i]);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    node_id         = 8'd5;
    next_flit       = '0;
    next_flit_valid = 1'b0;
    cpu_ready       = 1'b1;
    fwd_ready       = 1'b1;
    #12;
    check("rst_ready", next_flit_ready, 0);
    check("rst_cpu_valid", cpu_valid, 0);
    check("rst_fwd_valid", fwd_valid, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_err", err_count, 0);
    @(negedge nocclk);
    rst_n = 1'b1;
    tick(1);
    check("idle_ready", next_flit_ready, 1);

    // Test 1: a SINGLE addressed to this node goes to the CPU with two cycles of latency.
    f_h = mk(2'b11, 8'h11, 8'd5);
    push(f_h);
    check("t1_pkt1", pkt_count, 1);
    check("t1_cpu_v_n0", cpu_valid, 0);
    tick(1);
    check("t1_cpu_v_n1", cpu_valid, 0);
    tick(1);
    check("t1_cpu_v_n2", cpu_valid, 1);
    check("t1_cpu_data", cpu_flit, f_h);
    check("t1_fwd_v", fwd_valid, 0);
    tick(1);
    check("t1_pkt0", pkt_count, 0);
    check("t1_cpu_v_done", cpu_valid, 0);
    cpu_exp_q.push_back(f_h);
    check_port("t1_cpu", 1);
    check_port("t1_fwd", 0);

    // Test 2: a 4-flit packet to a remote node is forwarded only after its TAIL is stored.
    f_h  = mk(2'b00, 8'h21, 8'd9);
    f_b1 = mk(2'b01, 8'h22, 8'h00);
    f_b2 = mk(2'b01, 8'h23, 8'h00);
    f_t  = mk(2'b10, 8'h24, 8'h00);
    push(f_h);
    push(f_b1);
    push(f_b2);
    tick(4);
    check("t2_no_early_fwd", 64'(fwd_got.size() - fwd_rd), 0);
    check("t2_fwd_v_early", fwd_valid, 0);
    push(f_t);
    tick(10);
    fwd_exp_q.push_back(f_h);
    fwd_exp_q.push_back(f_b1);
    fwd_exp_q.push_back(f_b2);
    fwd_exp_q.push_back(f_t);
    check_port("t2_fwd", 0);
    check_port("t2_cpu", 1);
    check("t2_pkt0", pkt_count, 0);

    // Test 3: a broadcast while the CPU stalls. Each port takes each flit once.
    f_h  = mk(2'b00, 8'h31, 8'hFF);
    f_b1 = mk(2'b01, 8'h32, 8'h00);
    f_t  = mk(2'b10, 8'h33, 8'h00);
    cpu_ready = 1'b0;
    push(f_h);
    push(f_b1);
    push(f_t);
    tick(3);
    check("t3_fwd_one", 64'(fwd_got.size() - fwd_rd), 1);
    check("t3_fwd_v_done", fwd_valid, 0);
    check("t3_cpu_v_wait", cpu_valid, 1);
    check("t3_cpu_data", cpu_flit, f_h);
    check("t3_pkt_held", pkt_count, 1);
    cpu_ready = 1'b1;
    tick(10);
    cpu_exp_q.push_back(f_h);
    cpu_exp_q.push_back(f_b1);
    cpu_exp_q.push_back(f_t);
    fwd_exp_q.push_back(f_h);
    fwd_exp_q.push_back(f_b1);
    fwd_exp_q.push_back(f_t);
    check_port("t3_cpu", 1);
    check_port("t3_fwd", 0);
    check("t3_pkt0", pkt_count, 0);

    // Test 4: a stray BODY, then a packet closed by a SINGLE instead of a TAIL.
    push(mk(2'b01, 8'h40, 8'h00));
    check("t4_err1", err_count, 1);
    check("t4_pkt_stray", pkt_count, 0);
    f_h  = mk(2'b00, 8'h41, 8'd5);
    f_b1 = mk(2'b01, 8'h42, 8'h00);
    f_t  = mk(2'b11, 8'h43, 8'd9);
    push(f_h);
    push(f_b1);
    push(f_t);
    check("t4_err2", err_count, 2);
    check("t4_pkt2", pkt_count, 2);
    tick(15);
    cpu_exp_q.push_back(f_h);
    cpu_exp_q.push_back(f_b1);
    fwd_exp_q.push_back(f_t);
    check_port("t4_cpu", 1);
    check_port("t4_fwd", 0);
    check("t4_pkt0", pkt_count, 0);

    // Test 5: an oversize packet with outputs stalled. It is truncated at 4 entries and the rest is dropped.
    cpu_ready = 1'b0;
    fwd_ready = 1'b0;
    f_h  = mk(2'b00, 8'h51, 8'd9);
    f_b1 = mk(2'b01, 8'h52, 8'h00);
    f_b2 = mk(2'b01, 8'h53, 8'h00);
    f_b3 = mk(2'b01, 8'h54, 8'h00);
    push(f_h);
    push(f_b1);
    push(f_b2);
    check("t5_pkt_before", pkt_count, 0);
    push(f_b3);
    check("t5_pkt_trunc", pkt_count, 1);
    check("t5_err3", err_count, 3);
    check("t5_drop_ready0", next_flit_ready, 1);
    push(mk(2'b01, 8'h55, 8'h00));
    check("t5_drop_ready1", next_flit_ready, 1);
    push(mk(2'b01, 8'h56, 8'h00));
    check("t5_drop_ready2", next_flit_ready, 1);
    push(mk(2'b10, 8'h57, 8'h00));
    check("t5_full_ready", next_flit_ready, 0);
    check("t5_err_final", err_count, 3);
    check("t5_pkt_still1", pkt_count, 1);
    fwd_ready = 1'b1;
    tick(10);
    fwd_exp_q.push_back(f_h);
    fwd_exp_q.push_back(f_b1);
    fwd_exp_q.push_back(f_b2);
    fwd_exp_q.push_back(f_b3);
    check_port("t5_fwd", 0);
    check_port("t5_cpu", 1);
    check("t5_pkt0", pkt_count, 0);
    check("t5_ready_back", next_flit_ready, 1);

    // Test 6: reset while the FIFO holds 3 entries and a flit is being presented.
    cpu_ready = 1'b0;
    fwd_ready = 1'b0;
    push(mk(2'b11, 8'h61, 8'd5));
    push(mk(2'b00, 8'h62, 8'd9));
    push(mk(2'b01, 8'h63, 8'h00));
    tick(3);
    check("t6_cpu_v_pre", cpu_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_cpu_v", cpu_valid, 0);
    check("t6_rst_fwd_v", fwd_valid, 0);
    check("t6_rst_pkt", pkt_count, 0);
    check("t6_rst_err", err_count, 0);
    check("t6_rst_ready", next_flit_ready, 0);
    tick(1);
    rst_n = 1'b1;
    cpu_ready = 1'b1;
    fwd_ready = 1'b1;
    tick(1);
    f_h = mk(2'b11, 8'h64, 8'd9);
    push(f_h);
    tick(6);
    fwd_exp_q.push_back(f_h);
    check_port("t6_fwd", 0);
    check_port("t6_cpu", 1);
    check("t6_pkt0", pkt_count, 0);
    check("t6_err0", err_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
